// File: rtl/valu_resp_collector.sv
// valu_resp_collector
// Consumer end of the vector-ALU request/response interface. A sideband FIFO records
// {sew, mask_op, last} for every request issued to the ALU. Each in-order ALU response pops
// the head entry and is either passed through to writeback (arithmetic) or packed into a
// 64-bit mask word (compare). All outputs are registered, one cycle after alu_valid_i.
//
// Ports:
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   req_valid_i     request issued to the ALU this cycle
//   req_ready_o     sideband FIFO can accept a request
//   req_sew_i       element width code of the request (0=8b .. 3=64b)
//   req_mask_op_i   1 = compare op (response carries mask bits)
//   req_last_i      final chunk of the vector instruction
//   alu_valid_i     ALU response valid
//   alu_vec_i       ALU response data
//   wb_valid_o      writeback word valid (single-cycle pulse)
//   wb_data_o       writeback word
//   wb_mask_word_o  wb_data_o is a packed mask word
//   wb_last_o       wb_data_o ends the instruction
//   err_o           sticky: response arrived with an empty FIFO

module valu_resp_collector #(
    parameter int unsigned DATA_WIDTH = 64,  // packing logic assumes exactly 64
    parameter int unsigned SEW_WIDTH  = 2,
    parameter int unsigned FIFO_DEPTH = 8    // power of 2, >= ALU latency + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SEW_WIDTH-1:0]  req_sew_i,
    input  logic                  req_mask_op_i,
    input  logic                  req_last_i,
    input  logic                  alu_valid_i,
    input  logic [DATA_WIDTH-1:0] alu_vec_i,
    output logic                  wb_valid_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  wb_mask_word_o,
    output logic                  wb_last_o,
    output logic                  err_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [SEW_WIDTH-1:0] sew;
        logic                 mask_op;
        logic                 last;
    } sb_t;

    // Sideband FIFO
    sb_t             fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;
    sb_t             head;

    // Mask accumulation
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [6:0]            bit_ptr_q, bit_ptr_d;
    logic [6:0]            chunk_len;
    logic [7:0]            ptr_sum;
    logic [DATA_WIDTH-1:0] chunk_bits;
    logic [DATA_WIDTH-1:0] merged;
    logic                  flush;

    // Registered outputs
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic                  wb_mask_word_q, wb_mask_word_d;
    logic                  wb_last_q, wb_last_d;
    logic                  err_q, err_d;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
    assign full  = (count_q == CntW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = req_valid_i & ~full;
    assign pop   = alu_valid_i & ~empty;
    assign head  = fifo_q[rd_ptr_q];

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign count_d  = count_q + CntW'(push) - CntW'(pop);

    // A compare response carries 8 >> sew mask bits in its low end.
    assign chunk_len  = 7'd8 >> head.sew;
    assign chunk_bits = alu_vec_i & ~({DATA_WIDTH{1'b1}} << chunk_len);
    assign merged     = acc_q | (chunk_bits << bit_ptr_q[5:0]);
    assign ptr_sum    = {1'b0, bit_ptr_q} + {1'b0, chunk_len};
    assign flush      = (ptr_sum >= 8'd64) | head.last;

    always_comb begin
        acc_d          = acc_q;
        bit_ptr_d      = bit_ptr_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        wb_mask_word_d = wb_mask_word_q;
        wb_last_d      = wb_last_q;
        err_d          = err_q;

        if (alu_valid_i && empty) begin
            // Response with no matching request: drop it and flag the protocol error.
            err_d = 1'b1;
        end else if (pop) begin
            if (!head.mask_op) begin
                // Arithmetic passes straight through; a partial mask stays parked in acc.
                wb_valid_d     = 1'b1;
                wb_data_d      = alu_vec_i;
                wb_mask_word_d = 1'b0;
                wb_last_d      = head.last;
            end else if (flush) begin
                wb_valid_d     = 1'b1;
                wb_data_d      = merged;
                wb_mask_word_d = 1'b1;
                wb_last_d      = head.last;
                acc_d          = '0;
                bit_ptr_d      = '0;
            end else begin
                acc_d     = merged;
                bit_ptr_d = ptr_sum[6:0];
            end
        end
    end

    // FIFO storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{sew: req_sew_i, mask_op: req_mask_op_i, last: req_last_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            acc_q          <= '0;
            bit_ptr_q      <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            wb_mask_word_q <= 1'b0;
            wb_last_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            acc_q          <= acc_d;
            bit_ptr_q      <= bit_ptr_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            wb_mask_word_q <= wb_mask_word_d;
            wb_last_q      <= wb_last_d;
            err_q          <= err_d;
        end
    end

    assign req_ready_o    = ~full;
    assign wb_valid_o     = wb_valid_q;
    assign wb_data_o      = wb_data_q;
    assign wb_mask_word_o = wb_mask_word_q;
    assign wb_last_o      = wb_last_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_valu_resp_collector.sv
// Testbench for valu_resp_collector: directed vectors, a queue-based reference model checked
// on every negedge, and literal expectations at the key points of each scenario.

module tb_valu_resp_collector;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_sew_i;
    logic        req_mask_op_i;
    logic        req_last_i;
    logic        alu_valid_i;
    logic [63:0] alu_vec_i;
    logic        wb_valid_o;
    logic [63:0] wb_data_o;
    logic        wb_mask_word_o;
    logic        wb_last_o;
    logic        err_o;

    always #5 clk = ~clk;

    valu_resp_collector #(
        .DATA_WIDTH(64),
        .SEW_WIDTH (2),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_sew_i     (req_sew_i),
        .req_mask_op_i (req_mask_op_i),
        .req_last_i    (req_last_i),
        .alu_valid_i   (alu_valid_i),
        .alu_vec_i     (alu_vec_i),
        .wb_valid_o    (wb_valid_o),
        .wb_data_o     (wb_data_o),
        .wb_mask_word_o(wb_mask_word_o),
        .wb_last_o     (wb_last_o),
        .err_o         (err_o)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: pending requests and not-yet-flushed mask bits, oldest first.
    typedef struct {
        logic [1:0] sew;
        logic       mop;
        logic       last;
    } sb_t;
    sb_t sbq[$];
    bit  bitq[$];
    bit  m_err;

    logic        exp_v, exp_mw, exp_last, exp_err, exp_ready;
    logic [63:0] exp_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_valid", 64'(wb_valid_o), 64'(exp_v));
            chk("err", 64'(err_o), 64'(exp_err));
            chk("req_ready", 64'(req_ready_o), 64'(exp_ready));
            if (exp_v) begin
                chk("wb_data", wb_data_o, exp_data);
                chk("wb_mask_word", 64'(wb_mask_word_o), 64'(exp_mw));
                chk("wb_last", 64'(wb_last_o), 64'(exp_last));
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_sew_i = '0; req_mask_op_i = 1'b0; req_last_i = 1'b0;
        alu_valid_i = 1'b0; alu_vec_i = '0;
        @(posedge clk);
        sbq.delete();
        bitq.delete();
        m_err = 1'b0;
        exp_v = 1'b0; exp_data = '0; exp_mw = 1'b0; exp_last = 1'b0;
        exp_err = 1'b0; exp_ready = 1'b1;
        #1;
        rst_i = 1'b0;
    endtask

    // One clock: drive inputs, advance the model, return #1 after the edge.
    task automatic step(input logic rv, input logic [1:0] sew, input logic mop, input logic lst,
                        input logic av, input logic [63:0] vec);
        bit          ready_now;
        sb_t         e;
        int          n;
        logic [63:0] w;
        logic        nv, nm, nl;
        logic [63:0] nd;
        req_valid_i = rv; req_sew_i = sew; req_mask_op_i = mop; req_last_i = lst;
        alu_valid_i = av; alu_vec_i = vec;
        ready_now = sbq.size() < 8;
        nv = 1'b0; nd = exp_data; nm = exp_mw; nl = exp_last;
        if (av) begin
            if (sbq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                e = sbq.pop_front();
                if (!e.mop) begin
                    nv = 1'b1; nd = vec; nm = 1'b0; nl = e.last;
                end else begin
                    n = 8 >> e.sew;
                    for (int i = 0; i < n; i++) bitq.push_back(vec[i]);
                    if (bitq.size() == 64 || e.last) begin
                        w = '0;
                        foreach (bitq[i]) w[i] = bitq[i];
                        bitq.delete();
                        nv = 1'b1; nd = w; nm = 1'b1; nl = e.last;
                    end
                end
            end
        end
        if (rv && ready_now) begin
            e.sew = sew; e.mop = mop; e.last = lst;
            sbq.push_back(e);
        end
        @(posedge clk);
        exp_v = nv; exp_data = nd; exp_mw = nm; exp_last = nl;
        exp_err = m_err; exp_ready = sbq.size() < 8;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("reset req_ready", 64'(req_ready_o), 64'h1);
        chk("reset wb_valid", 64'(wb_valid_o), 64'h0);
        chk("reset err", 64'(err_o), 64'h0);

        // 1: arithmetic pass-through
        step(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hDEADBEEF_01234567);
        chk("t1 wb_valid", 64'(wb_valid_o), 64'h1);
        chk("t1 wb_data", wb_data_o, 64'hDEADBEEF_01234567);
        chk("t1 wb_mask_word", 64'(wb_mask_word_o), 64'h0);
        chk("t1 wb_last", 64'(wb_last_o), 64'h1);
        idle();

        // 2: sew=0 mask, 8 chunks of A5
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 1'b1, 1'(i == 7), 1'b0, 64'h0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFA5);
            if (i == 6) chk("t2 no wb before last", 64'(wb_valid_o), 64'h0);
        end
        chk("t2 wb_data", wb_data_o, 64'hA5A5A5A5_A5A5A5A5);
        chk("t2 wb_mask_word", 64'(wb_mask_word_o), 64'h1);
        chk("t2 wb_last", 64'(wb_last_o), 64'h1);
        idle();

        // 3: sew=3 mask, bits 1,0,1
        for (int i = 0; i < 3; i++) step(1'b1, 2'd3, 1'b1, 1'(i == 2), 1'b0, 64'h0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_0001);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFE);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h3);
        chk("t3 wb_data", wb_data_o, 64'h5);
        chk("t3 wb_last", 64'(wb_last_o), 64'h1);
        idle();

        // 4: sew=1 mask, 17 chunks, word wraps at the 16th
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 64'h0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 2'd1, 1'b1, 1'(i == 16), 1'b1, 64'hF);
            if (i == 15) chk("t4 no wb at 15", 64'(wb_valid_o), 64'h0);
        end
        chk("t4 full word", wb_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t4 wrap wb_last", 64'(wb_last_o), 64'h0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hF);
        chk("t4 tail word", wb_data_o, 64'hF);
        chk("t4 tail wb_last", 64'(wb_last_o), 64'h1);
        idle();

        // Arithmetic between mask chunks leaves the partial mask intact
        step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 64'h3);
        step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 64'h1);
        step(1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 64'h1234_5678);
        chk("mix arith data", wb_data_o, 64'h1234_5678);
        chk("mix arith mask_word", 64'(wb_mask_word_o), 64'h0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h2);
        chk("mix mask data", wb_data_o, 64'h27);
        idle();

        // 5: FIFO full, push dropped while full, one pop frees a slot
        for (int i = 0; i < 8; i++) step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("t5 full ready", 64'(req_ready_o), 64'h0);
        step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hAA);
        chk("t5 ready after pop", 64'(req_ready_o), 64'h1);
        step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 64'h0);
        chk("t5 full again", 64'(req_ready_o), 64'h0);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'(i + 100));
        idle();

        // 6: response with empty FIFO sets sticky err
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'h55);
        chk("t6 err", 64'(err_o), 64'h1);
        chk("t6 no wb", 64'(wb_valid_o), 64'h0);
        idle();
        idle();
        chk("t6 err sticky", 64'(err_o), 64'h1);
        do_reset();
        chk("t6 err cleared", 64'(err_o), 64'h0);
        chk("t6 ready", 64'(req_ready_o), 64'h1);

        // Reset mid-operation: pending requests are discarded
        step(1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 64'h0);
        step(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 64'hFF);
        do_reset();
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 64'hFF);
        chk("rst mid err", 64'(err_o), 64'h1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
